// File: rtl/inf_nec_tx.sv
// inf_nec_tx: NEC infrared frame generator.
// Sends a full frame (lead, 32 data bits LSB first from {~data, data, ~addr, addr},
// stop bit, guard gap) or an NEC repeat code. o_inf_out is the active-low baseband
// level seen by the receiver: idle high, bursts low.
// Optional macro NEC_CARRIER_EN adds o_ir_tx, the carrier-modulated LED drive.
// Segment lengths default to NEC timing; they are parameters so that benches
// can run scaled-down frames.
//
// state  | meaning
// IDLE   | waiting for start / rpt_req, o_inf_out high
// LEAD_L | 9 ms lead burst, low
// LEAD_H | lead space, 4.5 ms (frame) or 2.25 ms (repeat), high
// BIT_L  | 560 us data burst, low
// BIT_H  | data space, 560 us for 0 or 1690 us for 1, high
// STOP_L | 560 us stop burst, low
// GAP    | idle-high guard after the stop bit
module inf_nec_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned GAP_US      = 40_000,
  parameter int unsigned CARRIER_HZ  = 38_000,
  parameter int unsigned LEAD_L_US   = 9000,
  parameter int unsigned LEAD_H_US   = 4500,
  parameter int unsigned RPT_H_US    = 2250,
  parameter int unsigned BIT_L_US    = 560,
  parameter int unsigned ZERO_H_US   = 560,
  parameter int unsigned ONE_H_US    = 1690,
  parameter int unsigned STOP_L_US   = 560
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_start,
  input  logic       i_rpt_req,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_data,
  output logic       o_inf_out,
  output logic       o_busy,
`ifdef NEC_CARRIER_EN
  output logic       o_ir_tx,
`endif
  output logic       o_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEAD_L = 3'd1;
  localparam logic [2:0] S_LEAD_H = 3'd2;
  localparam logic [2:0] S_BIT_L  = 3'd3;
  localparam logic [2:0] S_BIT_H  = 3'd4;
  localparam logic [2:0] S_STOP_L = 3'd5;
  localparam logic [2:0] S_GAP    = 3'd6;

  localparam logic [31:0] DIV_RLD = 32'(CLK_FREQ_HZ / 1_000_000 - 1);

  // The timebase needs at least one cycle per microsecond and the carrier
  // needs at least one cycle per half period.
  if (CLK_FREQ_HZ < 1_000_000 || CARRIER_HZ == 0 || CLK_FREQ_HZ < 2 * CARRIER_HZ) begin : g_cfg_err
    $error("inf_nec_tx: invalid clock/carrier configuration");
  end

  logic [2:0]  r_state;
  logic [31:0] r_div;
  logic [31:0] r_us_left;
  logic [31:0] r_sh;
  logic [4:0]  r_bit;
  logic        r_is_rpt;
  logic        r_rpt_ok;

  logic [2:0]  w_nxt_state;
  logic [31:0] w_nxt_len;
  logic        w_tick;
  logic        w_seg_end;
  logic        w_accept_frm;
  logic        w_accept_rpt;
  logic        w_enter;
  logic        w_nxt_low;

  assign w_tick       = (r_state != S_IDLE) && (r_div == '0);
  assign w_seg_end    = w_tick && (r_us_left == '0);
  // start has priority over rpt_req; requests outside IDLE are simply dropped.
  assign w_accept_frm = (r_state == S_IDLE) && i_start;
  assign w_accept_rpt = (r_state == S_IDLE) && !i_start && i_rpt_req && r_rpt_ok;
  assign w_enter      = (w_nxt_state != r_state);
  assign w_nxt_low    = (w_nxt_state == S_LEAD_L) || (w_nxt_state == S_BIT_L) ||
                        (w_nxt_state == S_STOP_L);

  // Next state and the length (in us) of the segment being entered.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_len   = '0;
    case (r_state)
      S_IDLE: if (w_accept_frm || w_accept_rpt) begin
        w_nxt_state = S_LEAD_L;
        w_nxt_len   = LEAD_L_US;
      end
      S_LEAD_L: if (w_seg_end) begin
        w_nxt_state = S_LEAD_H;
        w_nxt_len   = r_is_rpt ? RPT_H_US : LEAD_H_US;
      end
      S_LEAD_H: if (w_seg_end) begin
        w_nxt_state = r_is_rpt ? S_STOP_L : S_BIT_L;
        w_nxt_len   = r_is_rpt ? STOP_L_US : BIT_L_US;
      end
      S_BIT_L: if (w_seg_end) begin
        w_nxt_state = S_BIT_H;
        w_nxt_len   = r_sh[0] ? ONE_H_US : ZERO_H_US;
      end
      S_BIT_H: if (w_seg_end) begin
        w_nxt_state = (r_bit == 5'd31) ? S_STOP_L : S_BIT_L;
        w_nxt_len   = (r_bit == 5'd31) ? STOP_L_US : BIT_L_US;
      end
      S_STOP_L: if (w_seg_end) begin
        w_nxt_state = S_GAP;
        w_nxt_len   = GAP_US;
      end
      S_GAP: if (w_seg_end) begin
        w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // FSM, segment timers, payload shifter and registered outputs.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_us_left <= '0;
      r_sh      <= '0;
      r_bit     <= '0;
      r_is_rpt  <= 1'b0;
      r_rpt_ok  <= 1'b0;
      o_inf_out <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      o_inf_out <= !w_nxt_low;
      o_busy    <= (w_nxt_state != S_IDLE);
      o_done    <= (r_state == S_GAP) && w_seg_end;

      if (w_enter) begin
        r_div     <= (w_nxt_state == S_IDLE) ? '0 : DIV_RLD;
        r_us_left <= (w_nxt_state == S_IDLE) ? '0 : w_nxt_len - 32'd1;
      end else if (r_state != S_IDLE) begin
        if (w_tick) begin
          r_div <= DIV_RLD;
          if (r_us_left != '0) r_us_left <= r_us_left - 32'd1;
        end else begin
          r_div <= r_div - 32'd1;
        end
      end

      if (w_accept_frm) begin
        r_sh     <= {~i_data, i_data, ~i_addr, i_addr};
        r_bit    <= '0;
        r_is_rpt <= 1'b0;
      end else if (w_accept_rpt) begin
        r_is_rpt <= 1'b1;
      end

      if ((r_state == S_BIT_H) && w_seg_end) begin
        r_sh  <= {1'b0, r_sh[31:1]};
        r_bit <= r_bit + 5'd1;
      end

      // A repeat code is only meaningful after a full frame has gone out.
      if ((r_state == S_STOP_L) && w_seg_end && !r_is_rpt) r_rpt_ok <= 1'b1;
    end
  end

`ifdef NEC_CARRIER_EN
  localparam logic [31:0] CAR_RLD = 32'(CLK_FREQ_HZ / (2 * CARRIER_HZ) - 1);

  logic [31:0] r_car;

  // Carrier: restarts high at each low-segment entry, silent while inf_out is high.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      o_ir_tx <= 1'b0;
      r_car   <= '0;
    end else if (!w_nxt_low) begin
      o_ir_tx <= 1'b0;
      r_car   <= '0;
    end else if (w_enter) begin
      o_ir_tx <= 1'b1;
      r_car   <= CAR_RLD;
    end else if (r_car == '0) begin
      o_ir_tx <= ~o_ir_tx;
      r_car   <= CAR_RLD;
    end else begin
      r_car <= r_car - 32'd1;
    end
  end
`else
  // Baseband-only build: no carrier divider.
`endif

endmodule
